// File: rtl/video_pkg.sv
// Shared video definitions for the scandoubler slice: default geometry and
// the packed pixel type used by consumers of the doubled stream.
package video_pkg;

  localparam int HCNT_W_DEF  = 10;
  localparam int COLOR_W_DEF = 6;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

endpackage

// File: rtl/sd_line_buffer.sv
// Double line buffer: simple dual-port RAM, one bank written while the other
// is read. The read port is registered; contents are never reset.
module sd_line_buffer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
) (
  input  logic              clk_sys,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 << ADDR_W;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // Write port, driven by the input pixel side.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port, advanced on output pixel ticks only.
  always_ff @(posedge clk_sys) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/scandoubler.sv
// 15 kHz -> 31 kHz line doubler: each input line is captured into one bank
// and the previous line is replayed twice at the doubled pixel rate.
module scandoubler
  import video_pkg::*;
#(
  parameter int HCNT_W     = HCNT_W_DEF,
  parameter int COLOR_W    = COLOR_W_DEF,
  parameter int SCAN_SHIFT = 1
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce_x1,
  input  logic               ce_x2,
  input  logic               scanlines,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  input  logic               hs_in,
  input  logic               vs_in,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic               hs_out,
  output logic               vs_out
);

  localparam int                PIX_W    = 3 * COLOR_W;
  localparam logic [HCNT_W-1:0] HCNT_MAX = {HCNT_W{1'b1}};
  localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1'b1);

  logic              hs_d1_r, hs_d2_r, vs_d1_r, vs_lat_r;
  logic              wr_bank_r, started_r, valid_r;
  logic [HCNT_W-1:0] in_hcnt_r, line_len_r, hs_len_r;
  logic [HCNT_W-1:0] out_hcnt_r;
  logic              out_line_r;
  logic              hs_s1_r, vs_s1_r, dim_s1_r, valid_s1_r;

  logic              line_start_s, hs_rise_s, wrap_s, wr_en_s;
  logic [PIX_W-1:0]  rd_pix_s;
  logic [COLOR_W-1:0] r_pix_s, g_pix_s, b_pix_s;

  assign line_start_s = ce_x1 & hs_d2_r & ~hs_d1_r;
  assign hs_rise_s    = ce_x1 & ~hs_d2_r & hs_d1_r;
  assign wrap_s       = (line_len_r != '0) && (out_hcnt_r == (line_len_r - HCNT_ONE));
  // A saturated counter means the line overran the buffer: drop the excess.
  assign wr_en_s      = ce_x1 && (in_hcnt_r != HCNT_MAX);

  sd_line_buffer #(
    .ADDR_W (HCNT_W),
    .DATA_W (PIX_W)
  ) u_line_buffer (
    .clk_sys (clk_sys),
    .wr_en   (wr_en_s),
    .wr_addr ({wr_bank_r, in_hcnt_r}),
    .wr_data ({r_in, g_in, b_in}),
    .rd_en   (ce_x2),
    .rd_addr ({~wr_bank_r, out_hcnt_r}),
    .rd_data (rd_pix_s)
  );

  // Input side: sync edge detection, line measurement and bank switching.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_d1_r    <= 1'b1;
      hs_d2_r    <= 1'b1;
      vs_d1_r    <= 1'b1;
      vs_lat_r   <= 1'b1;
      wr_bank_r  <= 1'b0;
      started_r  <= 1'b0;
      valid_r    <= 1'b0;
      in_hcnt_r  <= '0;
      line_len_r <= '0;
      hs_len_r   <= '0;
    end else if (ce_x1) begin
      hs_d1_r <= hs_in;
      hs_d2_r <= hs_d1_r;
      vs_d1_r <= vs_in;
      if (line_start_s) begin
        line_len_r <= in_hcnt_r;
        in_hcnt_r  <= '0;
        wr_bank_r  <= ~wr_bank_r;
        vs_lat_r   <= vs_d1_r;
        started_r  <= 1'b1;
        valid_r    <= valid_r | started_r;
      end else begin
        if (hs_rise_s) begin
          hs_len_r <= in_hcnt_r;
        end
        if (in_hcnt_r != HCNT_MAX) begin
          in_hcnt_r <= in_hcnt_r + HCNT_ONE;
        end
      end
    end
  end

  // Output side: replay position; an input line start outranks a wrap.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      out_hcnt_r <= '0;
      out_line_r <= 1'b0;
    end else if (ce_x2) begin
      if (line_start_s) begin
        out_hcnt_r <= '0;
        out_line_r <= 1'b0;
      end else if (wrap_s) begin
        out_hcnt_r <= '0;
        out_line_r <= 1'b1;
      end else if (out_hcnt_r != HCNT_MAX) begin
        out_hcnt_r <= out_hcnt_r + HCNT_ONE;
      end
    end
  end

  // Sideband stage aligned with the RAM read latency.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1_r    <= 1'b1;
      vs_s1_r    <= 1'b1;
      dim_s1_r   <= 1'b0;
      valid_s1_r <= 1'b0;
    end else if (ce_x2) begin
      hs_s1_r    <= !(out_hcnt_r < hs_len_r);
      vs_s1_r    <= vs_lat_r;
      dim_s1_r   <= scanlines & out_line_r;
      valid_s1_r <= valid_r;
    end
  end

  // Scanline dimming of the pixel read back from the buffer.
  always_comb begin
    r_pix_s = rd_pix_s[PIX_W-1 -: COLOR_W];
    g_pix_s = rd_pix_s[2*COLOR_W-1 -: COLOR_W];
    b_pix_s = rd_pix_s[COLOR_W-1:0];
    if (dim_s1_r) begin
      r_pix_s = r_pix_s >> SCAN_SHIFT;
      g_pix_s = g_pix_s >> SCAN_SHIFT;
      b_pix_s = b_pix_s >> SCAN_SHIFT;
    end else begin
      r_pix_s = rd_pix_s[PIX_W-1 -: COLOR_W];
    end
  end

  // Output registers; blanked with inactive syncs until two lines are seen.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
    end else if (ce_x2) begin
      if (valid_s1_r) begin
        r_out  <= r_pix_s;
        g_out  <= g_pix_s;
        b_out  <= b_pix_s;
        hs_out <= hs_s1_r;
        vs_out <= vs_s1_r;
      end else begin
        r_out  <= '0;
        g_out  <= '0;
        b_out  <= '0;
        hs_out <= 1'b1;
        vs_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scandoubler.sv
// Scoreboard bench for scandoubler: the stimulus side queues the expected
// output of every ce_x2 tick, a monitor pops and compares them.
module tb_scandoubler;
  import video_pkg::*;

  localparam int HS_LOW = 40;
  localparam int HS_LEN = HS_LOW - 1;

  logic       clk_sys = 1'b0;
  logic       reset_n, ce_x1, ce_x2, scanlines, hs_in, vs_in;
  logic [5:0] r_in, g_in, b_in, r_out, g_out, b_out;
  logic       hs_out, vs_out;

  typedef struct {
    int   t;
    rgb_t px;
    logic hs;
    logic vs;
  } exp_t;

  exp_t exp_q[$];
  int   tick;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ph;
  int   len_p;

  scandoubler #(.HCNT_W(10), .COLOR_W(6), .SCAN_SHIFT(1)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ce_x1     (ce_x1),
    .ce_x2     (ce_x2),
    .scanlines (scanlines),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out),
    .hs_out    (hs_out),
    .vs_out    (vs_out)
  );

  always #5 clk_sys = ~clk_sys;

  // Stimulus pixel at input tick n (line n/len_p, position n%len_p).
  function automatic rgb_t pix(input int n);
    int   ln, k;
    rgb_t p;
    ln = n / len_p;
    k  = n % len_p;
    if (ph == 0 && ln >= 4 && ln <= 7) begin
      p.r = 6'h3F; p.g = 6'h3F; p.b = 6'h3F;
    end else begin
      p.r = 6'(k); p.g = 6'(k + 21); p.b = 6'(63 - k);
    end
    return p;
  endfunction

  function automatic logic scan_at(input int n);
    int ln;
    ln = n / len_p;
    return (ph == 1) || (ln >= 4 && ln <= 6);
  endfunction

  function automatic logic vs_at(input int n);
    return !(ph == 0 && n >= 8 * len_p + 100 && n < 11 * len_p + 100);
  endfunction

  task automatic push_idle(input int t0, input int t1);
    exp_t e;
    for (int t = t0; t <= t1; t++) begin
      e.t = t; e.px = '0; e.hs = 1'b1; e.vs = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Doubled output of line m-1, replayed after the line start of line m.
  task automatic push_window(input int m);
    int   ll, ts, h;
    logic ol;
    exp_t e;
    ll = (len_p - 1 > 1023) ? 1023 : len_p - 1;
    ts = 2 * (len_p * m + 1) + 2;
    for (int j = 0; j < 2 * len_p; j++) begin
      ol   = (j >= ll);
      h    = ol ? (j - ll) % ll : j;
      e.t  = ts + j;
      e.px = pix(len_p * (m - 1) + 2 + h);
      if (ol && scan_at((e.t - 1) / 2)) begin
        e.px.r = e.px.r >> 1; e.px.g = e.px.g >> 1; e.px.b = e.px.b >> 1;
      end
      e.hs = (h < HS_LEN) ? 1'b0 : 1'b1;
      e.vs = vs_at(len_p * m);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_line(input int m, input int ticks);
    int   n;
    rgb_t p;
    for (int k = 0; k < ticks; k++) begin
      n = m * len_p + k;
      p = pix(n);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_sys);
        ce_x1 = (c == 0);
        ce_x2 = (c == 0) || (c == 2);
        if (c == 0) begin
          hs_in     = (k < HS_LOW) ? 1'b0 : 1'b1;
          vs_in     = vs_at(n);
          scanlines = scan_at(n);
          r_in = p.r; g_in = p.g; b_in = p.b;
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d expected ticks left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: samples 1 time unit after each ce_x2 edge.
  always @(posedge clk_sys) begin
    exp_t e;
    if (!reset_n) begin
      tick = 0;
    end else if (ce_x2) begin
      #1;
      while (exp_q.size() > 0 && exp_q[0].t <= tick) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (e.t != tick || {r_out, g_out, b_out, hs_out, vs_out} !== {e.px, e.hs, e.vs}) begin
          n_err++;
          $display("FAIL out@tick%0d (t=%0d): got rgb=%h/%h/%h hs=%b vs=%b, required rgb=%h/%h/%h hs=%b vs=%b",
                   e.t, tick, r_out, g_out, b_out, hs_out, vs_out,
                   e.px.r, e.px.g, e.px.b, e.hs, e.vs);
        end
      end
      tick++;
    end
  end

  initial begin
    reset_n = 1'b0; ce_x1 = 1'b0; ce_x2 = 1'b0; scanlines = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; r_in = 6'd0; g_in = 6'd0; b_in = 6'd0;
    ph = 0; len_p = 504;
    repeat (4) @(negedge clk_sys);

    // Ramp, scanlines on constant white, vsync pulse, then a mid-line reset.
    push_idle(0, 2 * len_p + 3);
    reset_n = 1'b1;
    for (int m = 0; m < 14; m++) begin
      if (m >= 1 && m <= 12) push_window(m);
      drive_line(m, (m == 13) ? 300 : len_p);
    end
    check_drained("phaseA_drain");

    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({r_out, g_out, b_out, hs_out, vs_out} !== {18'h0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got rgb=%h/%h/%h hs=%b vs=%b, required 0/0/0 hs=1 vs=1",
               r_out, g_out, b_out, hs_out, vs_out);
    end
    ce_x1 = 1'b0; ce_x2 = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Over-long lines: counter saturates and the replay wraps at 1023.
    ph = 1; len_p = 1100;
    push_idle(0, 2 * len_p + 3);
    reset_n = 1'b1;
    for (int m = 0; m < 4; m++) begin
      if (m >= 1 && m <= 2) push_window(m);
      drive_line(m, len_p);
    end
    check_drained("phaseB_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
